// File: rtl/s08_bus_arbiter_pkg.sv
// s08_bus_arbiter_pkg: shared state encodings, default widths and counter sizing helper
package s08_bus_arbiter_pkg;
  localparam int AW_DEF = 11;
  localparam int DW_DEF = 8;
  localparam logic [1:0] ST_CPU     = 2'd0;
  localparam logic [1:0] ST_PARK    = 2'd1;
  localparam logic [1:0] ST_DMA     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;
  function automatic int cw(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction
endpackage

// File: rtl/s08_bus_mux.sv
// s08_bus_mux: combinational bus source select from arbiter state
module s08_bus_mux
  import s08_bus_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic [1:0]    state,
  input  logic [AW-1:0] cpu_abus,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] dma_abus,
  input  logic [DW-1:0] dma_dout,
  input  logic          dma_rd,
  input  logic          dma_wr,
  output logic [AW-1:0] bus_abus,
  output logic [DW-1:0] bus_dout,
  output logic          bus_rd,
  output logic          bus_wr
);
  logic dma, cpu;
  always_comb begin
    dma = state == ST_DMA;
    cpu = state == ST_CPU;
    bus_abus = dma ? dma_abus : cpu_abus;
    bus_dout = dma ? dma_dout : cpu_dout;
    bus_rd = dma ? dma_rd : cpu & cpu_rd;
    bus_wr = dma ? dma_wr : cpu & cpu_wr;
  end
endmodule

// File: rtl/s08_bus_arbiter.sv
// s08_bus_arbiter: parks the CPU at a fetch boundary, grants a bounded DMA burst,
// then enforces a CPU instruction cooldown before the next grant
module s08_bus_arbiter
  import s08_bus_arbiter_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int MAX_BURST     = 16,
  parameter int MIN_CPU_INSNS = 2
) (
  input  logic          clk50,
  input  logic          resetPBin,
  input  logic          cpu_tick,
  input  logic          cpu_bound,
  input  logic [AW-1:0] cpu_abus,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  output logic          cpu_step,
  output logic          cpu_hold,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_abus,
  input  logic [DW-1:0] dma_dout,
  input  logic          dma_rd,
  input  logic          dma_wr,
  output logic          dma_gnt,
  output logic [AW-1:0] bus_abus,
  output logic [DW-1:0] bus_dout,
  output logic          bus_rd,
  output logic          bus_wr
);
  localparam int BW = cw(MAX_BURST);
  localparam int CW = cw(MIN_CPU_INSNS);
  logic [1:0]    state;
  logic [BW-1:0] burst_cnt;
  logic [CW-1:0] cool_cnt;
  logic          xfer, last;
  always_comb begin
    cpu_hold = state != ST_CPU;
    dma_gnt = state == ST_DMA;
    cpu_step = cpu_tick & ~cpu_hold;
    xfer = dma_rd | dma_wr;
    last = xfer && burst_cnt == BW'(MAX_BURST - 1);
  end
  always_ff @(posedge clk50 or negedge resetPBin)
    if (!resetPBin) begin
      state <= ST_CPU;
      burst_cnt <= '0;
      cool_cnt <= '0;
    end else
      case (state)
        ST_CPU: begin
          if (cpu_step && cpu_bound && cool_cnt != '0) cool_cnt <= cool_cnt - CW'(1);
          if (dma_req && cool_cnt == '0) state <= ST_PARK;
        end
        ST_PARK: state <= !dma_req ? ST_CPU : cpu_bound ? ST_DMA : ST_PARK;
        ST_DMA: begin
          if (xfer) burst_cnt <= burst_cnt + BW'(1);
          if (!dma_req || last) state <= ST_RELEASE;
        end
        default: begin
          burst_cnt <= '0;
          cool_cnt <= CW'(MIN_CPU_INSNS);
          state <= ST_CPU;
        end
      endcase
  s08_bus_mux #(.AW(AW), .DW(DW)) u_mux (
    .state(state),
    .cpu_abus(cpu_abus),
    .cpu_dout(cpu_dout),
    .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr),
    .dma_abus(dma_abus),
    .dma_dout(dma_dout),
    .dma_rd(dma_rd),
    .dma_wr(dma_wr),
    .bus_abus(bus_abus),
    .bus_dout(bus_dout),
    .bus_rd(bus_rd),
    .bus_wr(bus_wr)
  );
endmodule

// File: tb/tb_s08_bus_arbiter.sv
// tb_s08_bus_arbiter: randomized scoreboard bench against a flag/counter reference model
module tb_s08_bus_arbiter;
  localparam int AW = 11, DW = 8, MAXB = 16, MINI = 2;
  logic clk50 = 0, resetPBin = 0;
  logic cpu_tick = 0, cpu_bound = 0, cpu_rd = 0, cpu_wr = 0;
  logic [AW-1:0] cpu_abus = '0, dma_abus = '0;
  logic [DW-1:0] cpu_dout = '0, dma_dout = '0;
  logic dma_req = 0, dma_rd = 0, dma_wr = 0;
  logic cpu_step, cpu_hold, dma_gnt, bus_rd, bus_wr;
  logic [AW-1:0] bus_abus;
  logic [DW-1:0] bus_dout;
  typedef struct packed {
    logic step, hold, gnt;
    logic [AW-1:0] abus;
    logic [DW-1:0] dout;
    logic rd, wr;
  } obs_t;
  obs_t q[$];
  obs_t mon_e, mon_g;
  int checks = 0, errors = 0, cyc = 0;
  bit parked, granted, releasing;
  int burst, cool;
  bit req_r = 0;

  always #5 clk50 = ~clk50;

  s08_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB), .MIN_CPU_INSNS(MINI)) dut (
    .clk50(clk50), .resetPBin(resetPBin),
    .cpu_tick(cpu_tick), .cpu_bound(cpu_bound), .cpu_abus(cpu_abus), .cpu_dout(cpu_dout),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_step(cpu_step), .cpu_hold(cpu_hold),
    .dma_req(dma_req), .dma_abus(dma_abus), .dma_dout(dma_dout), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_gnt(dma_gnt), .bus_abus(bus_abus), .bus_dout(bus_dout), .bus_rd(bus_rd), .bus_wr(bus_wr)
  );

  task automatic drive(input bit rst_n, tick, bound, req, drd, dwr,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    obs_t e;
    bit held, xfer, go;
    @(posedge clk50);
    #1;
    resetPBin = rst_n; cpu_tick = tick; cpu_bound = bound; dma_req = req;
    dma_rd = drd; dma_wr = dwr; dma_abus = da; dma_dout = dd;
    cpu_abus = AW'($urandom); cpu_dout = DW'($urandom);
    cpu_rd = 1'($urandom); cpu_wr = 1'($urandom);
    if (!rst_n) begin
      parked = 0; granted = 0; releasing = 0; burst = 0; cool = 0;
    end
    held = parked | granted | releasing;
    e.step = tick & ~held;
    e.hold = held;
    e.gnt = granted;
    e.abus = granted ? da : cpu_abus;
    e.dout = granted ? dd : cpu_dout;
    e.rd = granted ? drd : !held && cpu_rd;
    e.wr = granted ? dwr : !held && cpu_wr;
    q.push_back(e);
    if (!rst_n) return;
    if (releasing) begin
      releasing = 0; burst = 0; cool = MINI;
    end else if (granted) begin
      xfer = drd | dwr;
      if (xfer) burst++;
      if (!req || (xfer && burst == MAXB)) begin
        granted = 0; releasing = 1;
      end
    end else if (parked) begin
      if (!req) parked = 0;
      else if (bound) begin
        parked = 0; granted = 1;
      end
    end else begin
      go = req && cool == 0;
      if (e.step && bound && cool > 0) cool--;
      if (go) parked = 1;
    end
  endtask

  task automatic idle(input int n, input bit bound);
    repeat (n) drive(1, 1, bound, 0, 0, 0, AW'($urandom), DW'($urandom));
  endtask

  always @(negedge clk50) begin
    cyc++;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_g = '{cpu_step, cpu_hold, dma_gnt, bus_abus, bus_dout, bus_rd, bus_wr};
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL cycle %0d step/hold/gnt/abus/dout/rd/wr got %b%b%b %h %h %b%b exp %b%b%b %h %h %b%b",
                 cyc, mon_g.step, mon_g.hold, mon_g.gnt, mon_g.abus, mon_g.dout, mon_g.rd, mon_g.wr,
                 mon_e.step, mon_e.hold, mon_e.gnt, mon_e.abus, mon_e.dout, mon_e.rd, mon_e.wr);
      end
    end
  end

  initial begin
    repeat (3) drive(0, 1, 1, 0, 0, 0, '0, '0);
    repeat (100) drive(1, 1, 1'($urandom), 0, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
    idle(2, 1);
    drive(1, 0, 1, 1, 0, 0, '0, '0);
    drive(1, 0, 1, 1, 0, 0, '0, '0);
    drive(1, 0, 1, 1, 0, 1, 11'h008, 8'h5A);
    drive(1, 0, 1, 0, 0, 0, '0, '0);
    idle(4, 1);
    repeat (24) drive(1, 0, 1, 1, 1'($urandom), 1, AW'($urandom), DW'($urandom));
    repeat (16) drive(1, 1'($urandom), 1'($urandom), 1, 1, 0, AW'($urandom), DW'($urandom));
    drive(1, 0, 1, 0, 0, 0, '0, '0);
    idle(4, 1);
    repeat (3) drive(1, 0, 0, 1, 1, 1, AW'($urandom), DW'($urandom));
    drive(1, 0, 0, 0, 1, 0, '0, '0);
    idle(4, 1);
    repeat (2) drive(1, 0, 1, 1, 0, 0, '0, '0);
    repeat (5) drive(1, 0, 1, 1, 0, 1, AW'($urandom), DW'($urandom));
    drive(0, 0, 1, 1, 0, 1, AW'($urandom), DW'($urandom));
    repeat (22) drive(1, 0, 1, 1, 1, 0, AW'($urandom), DW'($urandom));
    drive(1, 0, 1, 0, 0, 0, '0, '0);
    idle(4, 1);
    repeat (10) drive(1, 1'($urandom), 1'($urandom), 0, 1, 1'($urandom), AW'($urandom), DW'($urandom));
    repeat (3000) begin
      if ($urandom_range(7) == 0) req_r = ~req_r;
      drive($urandom_range(499) != 0, 1'($urandom), $urandom_range(3) != 0, req_r,
            $urandom_range(3) != 0, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    @(negedge clk50);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
